// File: rtl/muldiv_pkg.sv
// Shared encodings for the multicycle multiply/divide unit: op codes and FSM states.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PREP = 2'b01,
      RUN  = 2'b10,
      FIX  = 2'b11
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration bit: right-shifting shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH:0]   acc_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH:0]   acc_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shl;
   logic [WIDTH:0] diff;
   logic [WIDTH:0] sel;

   always_comb begin
      sum  = acc_i + {1'b0, b_i};
      shl  = {acc_i[WIDTH-1:0], q_i[WIDTH-1]};
      diff = shl - {1'b0, b_i};
      sel  = q_i[0] ? sum : acc_i;
      if (is_div) begin
         // remainder stays below the divisor, so WIDTH+1 bits never overflow
         if (shl >= {1'b0, b_i}) begin
            acc_o = diff;
            q_o   = {q_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o = shl;
            q_o   = {q_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_o = {1'b0, sel[WIDTH:1]};
         q_o   = {sel[0], q_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide engine with start/busy/done handshake and mthi/mtlo writes.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             hi_wr,
   input  logic             lo_wr,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int N     = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = $clog2(N + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t state, state_nxt;

   logic [1:0]         op_r;
   logic [WIDTH:0]     acc_r;
   logic [WIDTH-1:0]   q_r;
   logic [WIDTH-1:0]   b_r;
   logic [CNT_W-1:0]   cnt;
   logic               neg_q, neg_r, dz_r;
   logic               op_signed, op_div;
   logic [WIDTH:0]     acc_nxt;
   logic [WIDTH-1:0]   q_nxt;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   res_hi, res_lo;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
      return en ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_if2(input logic [2*WIDTH-1:0] v, input logic en);
      return en ? -v : v;
   endfunction

   assign op_signed = (op_r == OP_MULT) || (op_r == OP_DIV);
   assign op_div    = (op_r == OP_DIV)  || (op_r == OP_DIVU);

   // iteration chain: BITS_PER_CYCLE single-bit steps per RUN cycle
   logic [WIDTH:0]   acc_s0;
   logic [WIDTH-1:0] q_s0;

   muldiv_step #(.WIDTH(WIDTH)) u_step0 (
      .is_div (op_div),
      .acc_i  (acc_r),
      .q_i    (q_r),
      .b_i    (b_r),
      .acc_o  (acc_s0),
      .q_o    (q_s0)
   );

   if (BITS_PER_CYCLE == 2) begin : g_two
      muldiv_step #(.WIDTH(WIDTH)) u_step1 (
         .is_div (op_div),
         .acc_i  (acc_s0),
         .q_i    (q_s0),
         .b_i    (b_r),
         .acc_o  (acc_nxt),
         .q_o    (q_nxt)
      );
   end else begin : g_one
      assign acc_nxt = acc_s0;
      assign q_nxt   = q_s0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = PREP;
         PREP:    state_nxt = RUN;
         RUN:     if (cnt == CNT_ONE) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // sign correction of the magnitude result
   always_comb begin
      prod = neg_if2({acc_r[WIDTH-1:0], q_r}, neg_q);
      if (op_div) begin
         res_lo = dz_r ? '1 : neg_if(q_r, neg_q);
         res_hi = neg_if(acc_r[WIDTH-1:0], neg_r);
      end else begin
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done        <= (state == FIX);
         div_by_zero <= (state == FIX) && dz_r;
         if (state == PREP)     busy <= 1'b1;
         else if (state == FIX) busy <= 1'b0;
         if (state == IDLE) begin
            if (hi_wr) hi <= wr_data;
            if (lo_wr) lo <= wr_data;
         end else if (state == FIX) begin
            hi <= res_hi;
            lo <= res_lo;
         end
      end
   end

   // working registers carry no reset; the FSM gates every use
   always_ff @(posedge clk) begin
      case (state)
         IDLE: begin
            if (start) begin
               op_r <= op;
               q_r  <= src_a;
               b_r  <= src_b;
            end
         end
         PREP: begin
            q_r   <= mag(q_r, op_signed);
            b_r   <= mag(b_r, op_signed);
            acc_r <= '0;
            cnt   <= CNT_LOAD;
            neg_q <= op_signed && (q_r[WIDTH-1] ^ b_r[WIDTH-1]);
            neg_r <= op_signed && q_r[WIDTH-1];
            dz_r  <= op_div && (b_r == '0);
         end
         RUN: begin
            acc_r <= acc_nxt;
            q_r   <= q_nxt;
            cnt   <= cnt - CNT_ONE;
         end
         default: ;
      endcase
   end

endmodule
